// File: rtl/axi_dds_slave_regs.sv
// AXI4-Lite register responder and phase accumulator for the DDS datapath.
// Holds CTRL/FTW/POFF/SCRATCH and runs the 32-bit accumulator they control.
// Ports:
//   s00_axi_aclk, s00_axi_aresetn : clock, async active-low reset
//   s00_axi_aw* / w* / b*         : AXI4-Lite write address, data, response
//   s00_axi_ar* / r*              : AXI4-Lite read address and data
//   phase_out                     : registered phase word (acc + POFF)
//   phase_valid                   : high while the accumulator is enabled
module axi_dds_slave_regs #(
    parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S00_AXI_ADDR_WIDTH = 4
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     phase_out,
    output logic                                phase_valid
);

    localparam int unsigned DW   = C_S00_AXI_DATA_WIDTH;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned NREG = 4;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}           rstate_t;

    // Protection bits and byte offset are not decoded.
    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Both responses are always OKAY.
    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

    logic [NREG-1:0][DW-1:0] regs;
    logic                    clr_pulse;

    // ---------------- write channel ----------------
    wstate_t         wstate, wstate_nxt;
    logic            aw_held, w_held, aw_held_nxt, w_held_nxt;
    logic            awready_nxt, wready_nxt, bvalid_nxt;
    logic [1:0]      waddr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;
    logic            aw_hs, w_hs, wr_en;

    assign aw_hs = s00_axi_awvalid & s00_axi_awready;
    assign w_hs  = s00_axi_wvalid  & s00_axi_wready;
    assign wr_en = (wstate == W_COMMIT);

    // Write FSM state register and held address/data flags
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wstate          <= W_IDLE;
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            waddr_q         <= 2'b00;
            wdata_q         <= '0;
            wstrb_q         <= '0;
        end else begin
            wstate          <= wstate_nxt;
            aw_held         <= aw_held_nxt;
            w_held          <= w_held_nxt;
            s00_axi_awready <= awready_nxt;
            s00_axi_wready  <= wready_nxt;
            s00_axi_bvalid  <= bvalid_nxt;
            if (aw_hs) waddr_q <= s00_axi_awaddr[3:2];
            if (w_hs) begin
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
        end
    end

    // Write FSM next state: commit once address and data are both in hand
    always_comb begin
        wstate_nxt = wstate;
        unique case (wstate)
            W_IDLE:   if ((aw_held | aw_hs) && (w_held | w_hs)) wstate_nxt = W_COMMIT;
            W_COMMIT: wstate_nxt = W_RESP;
            W_RESP:   if (s00_axi_bready) wstate_nxt = W_IDLE;
            default:  wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs, computed one cycle early so the ports are flops
    always_comb begin
        aw_held_nxt = aw_held;
        w_held_nxt  = w_held;
        if (aw_hs) aw_held_nxt = 1'b1;
        if (w_hs)  w_held_nxt  = 1'b1;
        if (wstate == W_COMMIT) begin
            aw_held_nxt = 1'b0;
            w_held_nxt  = 1'b0;
        end
        awready_nxt = (wstate_nxt == W_IDLE) && !aw_held_nxt;
        wready_nxt  = (wstate_nxt == W_IDLE) && !w_held_nxt;
        bvalid_nxt  = (wstate_nxt == W_RESP);
    end

    // Register file: byte-lane writes; CTRL bit1 only raises a one-cycle clear
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            regs      <= '0;
            clr_pulse <= 1'b0;
        end else begin
            clr_pulse <= 1'b0;
            if (wr_en) begin
                for (int unsigned b = 0; b < SW; b++) begin
                    if (wstrb_q[b]) regs[waddr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
                if (waddr_q == 2'd0) begin
                    regs[0][1] <= 1'b0;
                    clr_pulse  <= wstrb_q[0] & wdata_q[1];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t rstate, rstate_nxt;
    logic    arready_nxt, rvalid_nxt, ar_hs;

    assign ar_hs = s00_axi_arvalid & s00_axi_arready;

    // Read FSM state register; rdata sampled on the AR handshake edge
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rstate          <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            rstate          <= rstate_nxt;
            s00_axi_arready <= arready_nxt;
            s00_axi_rvalid  <= rvalid_nxt;
            if (ar_hs) s00_axi_rdata <= regs[s00_axi_araddr[3:2]];
        end
    end

    // Read FSM next state
    always_comb begin
        rstate_nxt = rstate;
        unique case (rstate)
            R_IDLE:  if (ar_hs) rstate_nxt = R_DATA;
            R_DATA:  if (s00_axi_rready) rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        arready_nxt = (rstate_nxt == R_IDLE);
        rvalid_nxt  = (rstate_nxt == R_DATA);
    end

    // ---------------- phase accumulator ----------------
    logic          en_q;
    logic [DW-1:0] ftw_q, poff_q, acc;

    // Control words are re-registered so register writes land one cycle later
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            en_q        <= 1'b0;
            ftw_q       <= '0;
            poff_q      <= '0;
            acc         <= '0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
        end else begin
            en_q   <= regs[0][0];
            ftw_q  <= regs[1];
            poff_q <= regs[2];
            if (clr_pulse)  acc <= '0;
            else if (en_q)  acc <= acc + ftw_q;
            phase_out   <= acc + poff_q;
            phase_valid <= en_q;
        end
    end

endmodule
